// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide).
// Optional feature macro ALU_MULDIV_FAST_MUL_EN: MUL* ops use a combinational multiplier and finish in one edge.
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam int DW = 2 * WIDTH;
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [2:0]       op_q;
    logic [DW-1:0]    acc;
    logic [DW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic             mul_neg_b;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] divisor;
    logic             q_neg;
    logic             r_neg;

    logic             accept;
    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             div_zero;
    logic             div_ovf;
    logic             fast;
    logic [DW-1:0]    a_ext;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] special_y;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] fix_y;
`ifdef ALU_MULDIV_FAST_MUL_EN
    logic [DW-1:0]    b_ext;
    logic [DW-1:0]    fast_prod;
    logic [WIDTH-1:0] fast_y;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready & ~flush;

    // Operand decode: signedness per funct3, sign-extension for multiply, magnitudes for divide.
    always_comb begin
        is_div    = op[2];
        a_signed  = is_div ? ~op[0] : ((op == 3'd1) || (op == 3'd2));
        b_signed  = is_div ? ~op[0] : (op == 3'd1);
        a_ext     = a_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        a_mag     = (a_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (b_signed && b[WIDTH-1]) ? -b : b;
        div_zero  = is_div && (b == '0);
        div_ovf   = is_div && ~op[0] && (a == MIN_INT) && (b == '1);
        special_y = op[1] ? (div_zero ? a : '0) : (div_zero ? '1 : a);
    end

`ifdef ALU_MULDIV_FAST_MUL_EN
    always_comb begin
        b_ext     = b_signed ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        fast_prod = a_ext * b_ext;
        fast_y    = (op[1:0] == 2'b00) ? fast_prod[WIDTH-1:0] : fast_prod[DW-1:WIDTH];
        fast      = ~is_div;
    end
`else
    assign fast = 1'b0;
`endif

    // Only WIDTH partial products are summed; the upper copies of a negative b's sign bit
    // reduce to subtracting a_ext<<WIDTH, which is exactly where mcand has shifted to.
    always_comb begin
        rem_sh = {rem, quot[WIDTH-1]};
        diff   = rem_sh - {1'b0, divisor};
        prod   = acc - (mul_neg_b ? mcand : '0);
        q_res  = q_neg ? -quot : quot;
        r_res  = r_neg ? -rem : rem;
        if (op_q[2])
            fix_y = op_q[1] ? r_res : q_res;
        else
            fix_y = (op_q[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[DW-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (div_zero || div_ovf || fast) ? DONE : BUSY;
            BUSY: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_q      <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            mul_neg_b <= 1'b0;
            rem       <= '0;
            quot      <= '0;
            divisor   <= '0;
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
        end else if (accept) begin
            cnt       <= CNT_INIT;
            op_q      <= op;
            acc       <= '0;
            mcand     <= a_ext;
            mplier    <= b;
            mul_neg_b <= b_signed & b[WIDTH-1];
            rem       <= '0;
            quot      <= a_mag;
            divisor   <= b_mag;
            q_neg     <= a_signed & b_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg     <= a_signed & a[WIDTH-1];
        end else if (state == BUSY) begin
            if (cnt != '0)
                cnt <= cnt - CW'(1);
            if (op_q[2]) begin
                if (!diff[WIDTH]) begin
                    rem  <= diff[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], 1'b1};
                end else begin
                    rem  <= rem_sh[WIDTH-1:0];
                    quot <= {quot[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    // y is left untouched by flush so a consumer that already took it keeps a stable value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            y <= '0;
        else if (accept && (div_zero || div_ovf))
            y <= special_y;
`ifdef ALU_MULDIV_FAST_MUL_EN
        else if (accept && fast)
            y <= fast_y;
`endif
        else if ((state == FIX) && !flush)
            y <= fix_y;
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed self-checking bench for alu_muldiv with an arithmetic reference model.
// Latency expectations follow ALU_MULDIV_FAST_MUL_EN when it is defined.
module tb_alu_muldiv;
    localparam int WIDTH = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] y;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_y = 32'd0;

    alu_muldiv #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] z);
        longint          sx, sz;
        longint unsigned ux, uz, p;
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        ux = {32'd0, x};
        uz = {32'd0, z};
        case (f)
            3'd0: begin p = ux * uz; return p[31:0]; end
            3'd1: begin p = sx * sz; return p[63:32]; end
            3'd2: begin p = sx * longint'(uz); return p[63:32]; end
            3'd3: begin p = ux * uz; return p[63:32]; end
            3'd4: begin
                if (z == 32'd0) return 32'hFFFF_FFFF;
                if (x == MIN_INT && z == 32'hFFFF_FFFF) return x;
                return 32'(sx / sz);
            end
            3'd5: begin
                if (z == 32'd0) return 32'hFFFF_FFFF;
                return 32'(ux / uz);
            end
            3'd6: begin
                if (z == 32'd0) return x;
                if (x == MIN_INT && z == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sx % sz);
            end
            default: begin
                if (z == 32'd0) return x;
                return 32'(ux % uz);
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] z);
        if (f[2] && (z == 32'd0 || (!f[0] && x == MIN_INT && z == 32'hFFFF_FFFF)))
            return 1;
`ifdef ALU_MULDIV_FAST_MUL_EN
        if (!f[2])
            return 1;
`endif
        return WIDTH + 2;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Continuous comparison against the model whenever a result is presented.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checkOutput("model_y", y, exp_y);
            checkOutput("in_ready_while_done", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic launchOp(input logic [2:0] f, input logic [31:0] x, input logic [31:0] z);
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready)
            checkOutput("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        op       = f;
        a        = x;
        b        = z;
        in_valid = 1'b1;
        exp_y    = model(f, x, z);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op       = ~f;
        a        = ~x;
        b        = z ^ 32'h5A5A_5A5A;
    endtask

    // Counts edges from the accepting edge (edge 1) until out_valid is seen.
    task automatic waitResult(input string name, input int exp_lat);
        int n;
        n = 1;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_latency"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic applyStimulus(input string name, input logic [2:0] f, input logic [31:0] x,
                                 input logic [31:0] z, input logic [31:0] lit);
        launchOp(f, x, z);
        waitResult(name, latency(f, x, z));
        checkOutput({name, "_y"}, y, lit);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
    endtask

    initial begin
        #12;
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_y", y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("mul_7_m3",     3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
        applyStimulus("mulh_min",     3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        applyStimulus("mulhu_min",    3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        applyStimulus("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
        applyStimulus("mulhsu_min",   3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        applyStimulus("mulhu_max",    3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        applyStimulus("mul_max",      3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
        applyStimulus("mulh_m1_m1",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        applyStimulus("div_m7_2",     3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        applyStimulus("rem_m7_2",     3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        applyStimulus("divu_100_7",   3'd5, 32'd100,       32'd7,         32'd14);
        applyStimulus("remu_100_7",   3'd7, 32'd100,       32'd7,         32'd2);
        applyStimulus("div_20_m6",    3'd4, 32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD);
        applyStimulus("rem_20_m6",    3'd6, 32'd20,        32'hFFFF_FFFA, 32'd2);
        applyStimulus("divu_min_max", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        applyStimulus("remu_min_max", 3'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        applyStimulus("divu_by0",     3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF);
        applyStimulus("rem_by0",      3'd6, 32'd5,         32'd0,         32'd5);
        applyStimulus("div_ovf",      3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        applyStimulus("rem_ovf",      3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Back-pressure: result held while out_ready stays low, new requests ignored.
        launchOp(3'd5, 32'd100, 32'd7);
        waitResult("bp", latency(3'd5, 32'd100, 32'd7));
        in_valid = 1'b1;
        op       = 3'd0;
        a        = 32'd3;
        b        = 32'd3;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_y_stable", y, 32'd14);
            checkOutput("bp_out_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("bp_release", {30'd0, out_valid, in_ready}, 32'd1);

        // Flush mid-multiply: unit idles, y keeps the previous result, no late result appears.
        launchOp(3'd0, 32'h0000_1234, 32'h0000_5678);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_idle", {30'd0, busy, in_ready}, 32'd1);
        checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_y_kept", y, 32'd14);
        begin
            int seen;
            seen = 0;
            repeat (40) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            checkOutput("flush_no_result", 32'(seen), 32'd0);
        end

        // Flush blocks a request presented in the same cycle.
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        op       = 3'd5;
        a        = 32'd9;
        b        = 32'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checkOutput("flush_blocks_accept", {30'd0, busy, in_ready}, 32'd1);

        // Flush in DONE with a handshake: consumer still sees the result, unit idles.
        launchOp(3'd7, 32'hFFFF_FFFF, 32'h0000_0010);
        waitResult("flush_done", latency(3'd7, 32'hFFFF_FFFF, 32'h0000_0010));
        checkOutput("flush_done_y", y, 32'd15);
        @(negedge clk);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        checkOutput("flush_done_idle", {30'd0, out_valid, in_ready}, 32'd1);
        checkOutput("flush_done_y_kept", y, 32'd15);

        // Asynchronous reset mid-divide, then a clean operation.
        launchOp(3'd4, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_mid_y", y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("post_rst_div", 3'd4, 32'd20, 32'hFFFF_FFFA, 32'hFFFF_FFFD);
        applyStimulus("post_rst_mul", 3'd0, 32'd7,  32'hFFFF_FFFD, 32'hFFFF_FFEB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
